serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle digit-serial subtractor; the inverse operation of the team's combinational 16-bit ripple adder.
- Computes DIFF = A − B − BIN over WIDTH/DIGIT cycles, one DIGIT-bit slice per cycle, with a borrow chain held in a register.
- Sits behind a valid/ready input port and a valid/ready output port so it can be dropped into datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; legal range 1..WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  A − B − BIN, modulo 2^WIDTH.
- bout  out  1  borrow-out; 1 when the unsigned result A − B − BIN < 0.
- ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Reset:
  - one clock edge with rst=1 puts the block in IDLE.
  - diff, bout, ovf, out_valid, the digit counter and the borrow register all become 0.
  - in_ready is 0 while rst=1 and 1 from the first cycle after rst deasserts.
- Elaboration: a WIDTH%DIGIT≠0 parameter set is a fatal error. N = WIDTH/DIGIT.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at the edge, latch a, b and bin into shift registers, clear the counter, and go to BUSY.
- BUSY:
  - in_ready=0. in_valid is ignored and no operands are captured.
  - Each cycle: {borrow', d} = a[DIGIT-1:0] − b[DIGIT-1:0] − borrow.
  - Shift the a and b registers right by DIGIT.
  - Shift d into the result register from the MSB end.
  - Increment the counter.
  - After the Nth BUSY cycle: load diff and bout from the final register/borrow values and go to DONE.
- Latency: out_valid rises exactly N edges after the accepting edge (N=4 at defaults).
- DONE:
  - out_valid=1; diff, bout and ovf are held stable.
  - When out_ready=1 at the edge, go to IDLE. out_valid falls on that edge.
  - diff, bout and ovf keep their last values until the next result; they are not cleared.
- No same-cycle turnaround: a new operand is accepted no earlier than the first IDLE cycle after the DONE handoff. Minimum initiation interval is N+2 cycles.
- out_ready while not in DONE is ignored.
- rst in any state (including mid-BUSY) aborts the operation and discards partial results. Reset values apply; no result is emitted.
- Arithmetic:
  - unsigned modulo 2^WIDTH.
  - bout is the final borrow.
  - With bin=1 and a=b, the result is all ones with bout=1.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - port ovf exists.
  - At completion, ovf = (a[MSB]≠b[MSB]) & (diff[MSB]≠a[MSB]), using the captured original operand MSBs, which are held in a dedicated 2-bit register.
  - Reset value 0; held in DONE like diff.
- Undefined: ovf port and its register are absent; all other behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg:
  - state enum (IDLE, BUSY, DONE).
  - default WIDTH and DIGIT localparams.
  - a function computing the counter width $clog2(N).
- One natural sub-module: sub_digit, a combinational DIGIT-bit subtract with borrow-in/borrow-out, instantiated once and time-multiplexed.
- The FSM, shift registers and handshake stay in serial_subtractor.

Test Plan:
- Basic subtract: a=0x1234, b=0x0034, bin=0 accepted at edge T → out_valid at T+4; diff=0x1200, bout=0.
- Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1; with SERIAL_SUB_OVF_EN, ovf=0.
- Borrow-in with equal operands: a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1.
- Signed overflow (SERIAL_SUB_OVF_EN): a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1.
- Backpressure and busy rejection:
  - hold out_ready=0 for 5 cycles in DONE → out_valid and diff stable; the next operand is accepted only after the out_ready handoff.
  - drive in_valid=1 with different operands during BUSY → ignored, result unchanged.
- Mid-operation reset: assert rst for 1 cycle at BUSY cycle 2 → no out_valid; all outputs 0; in_ready=1 the next cycle; a fresh 0x00FF−0x000F completes to 0x00F0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes the WIDTH/DIGIT digits; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
        int unsigned n;
        if (digit == 0) return 1;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor; ovf exists only with SERIAL_SUB_OVF_EN.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, diff, bout
    );

endinterface

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit subtract with borrow-in/borrow-out: {bout, d} = a - b - bin.
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);

    logic [DIGIT:0] wide;

    // The extra top bit goes to 1 exactly when the digit result is negative.
    always_comb begin
        wide = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
        d    = wide[DIGIT-1:0];
        bout = wide[DIGIT];
    end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles behind valid/ready ports.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_subtractor: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
    end

    localparam int unsigned      N     = WIDTH / DIGIT;
    localparam int unsigned      CNT_W = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             borrow_next;
    logic             bout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DIGIT-1:0] d;
    logic             last;

    sub_digit #(
        .DIGIT(DIGIT)
    ) u_sub_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .bin  (borrow_q),
        .d    (d),
        .bout (borrow_next)
    );

    // New digit enters at the MSB end; works unchanged when DIGIT == WIDTH.
    assign res_next = WIDTH'({d, res_q} >> DIGIT);
    assign last     = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        borrow_q <= bus.bin;
                        cnt_q    <= '0;
                    end
                end
                BUSY: begin
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    res_q    <= res_next;
                    borrow_q <= borrow_next;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last) begin
                        diff_q <= res_next;
                        bout_q <= borrow_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic [1:0] msb_q;
    logic       ovf_q;

    // Original operand MSBs are kept because a_q/b_q are shifted away during BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            msb_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && bus.in_valid) begin
            msb_q <= {bus.a[WIDTH-1], bus.b[WIDTH-1]};
        end else if (state_q == BUSY && last) begin
            ovf_q <= (msb_q[1] != msb_q[0]) && (res_next[WIDTH-1] != msb_q[1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operands vs an integer model.
module tb_serial_subtractor;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;
    localparam int unsigned N = W / D;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(
        .WIDTH(W),
        .DIGIT(D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Runs one transaction from IDLE; called and returns at a negedge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input int hold, input bit junk);
        int             r;
        int             rs;
        logic [W-1:0]   ed;
        logic           eb;
        logic           eo;
        r  = int'(a) - int'(b) - int'(bin);
        ed = W'(r);
        eb = (r < 0);
        rs = int'($signed(a)) - int'($signed(b)) - int'(bin);
        eo = (rs < -32768) || (rs > 32767);

        wait_ready();
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
        if (junk) begin
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            bus.bin       = 1'($urandom);
            bus.out_ready = 1'b1;
        end else begin
            bus.in_valid = 1'b0;
        end
        for (int i = 1; i <= int'(N); i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i < int'(N)) chk("early_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 32'd1);
        chk("diff", 32'(bus.diff), 32'(ed));
        chk("bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(bus.ovf), 32'(eo));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_diff", 32'(bus.diff), 32'(ed));
            chk("hold_bout", 32'(bus.bout), 32'(eb));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("handoff_valid", 32'(bus.out_valid), 32'd0);
        chk("handoff_in_ready", 32'(bus.in_ready), 32'd1);
        chk("handoff_diff_held", 32'(bus.diff), 32'(ed));
    endtask

    initial begin
        logic any_valid;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        do_op(16'h1234, 16'h0034, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h0005, 16'h0005, 1'b1, 1, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h4321, 16'h1111, 1'b0, 5, 1'b1);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);

        // Abort mid-BUSY: reset lands on the second BUSY edge.
        wait_ready();
        bus.a        = 16'hAAAA;
        bus.b        = 16'h1111;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_bout", 32'(bus.bout), 32'd0);
        chk("abort_in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        any_valid = 1'b0;
        for (int i = 0; i < int'(N) + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0) any_valid = 1'b1;
        end
        chk("abort_no_result", 32'(any_valid), 32'd0);
        do_op(16'h00FF, 16'h000F, 1'b0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                  1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
